calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
Keypad-driven controller that sequences the two-operand BCD add/subtract ALU of the calculator. It assembles operand A, the operator and operand B from single-cycle key events, drives bcd1/bcd2/op_selected into the ALU, and holds op_selected for a settle window. It then captures the ALU result and sign, flags overflow, and supplies the digit value to the display driver. It also supports chaining a result into the next operation.

Parameters:
MAX_DIGITS, 4, digits accepted per operand; fixed to 4 to match the 16-bit BCD ALU ports.
SETTLE_CYCLES, 1, clocks op_selected is held before the result is captured (range 1..15).

Ports:
clk  in  1  system clock; all state changes on the rising edge.
clear_n  in  1  asynchronous, active-low reset.
key_valid  in  1  one-cycle pulse; key_code is valid in that cycle.
key_code  in  4  0-9 digit, 4'hA add, 4'hB subtract, 4'hE equals, 4'hC clear-all; any other code is ignored.
key_ready  out  1  high when a key can be accepted.
bcd1  out  16  operand A to the ALU.
bcd2  out  16  operand B to the ALU.
op_selected  out  2  to the ALU: 2'b01 add, 2'b10 subtract, 2'b00 idle.
alu_bcd_out  in  16  ALU result, combinational from the ALU.
alu_special  in  1  ALU negative-result flag.
display_bcd  out  16  value currently shown.
display_neg  out  1  shown value is negative.
result_valid  out  1  high while a captured result is shown.
overflow  out  1  sticky error flag; display shows 0000.

Behaviour:
- Reset (clear_n low, asynchronous): state S_A; bcd1, bcd2, display_bcd = 0; op_selected = 2'b00; key_ready = 1; display_neg, result_valid, overflow = 0; digit counters and pending op = 0.
- A key is accepted only when key_valid and key_ready are both high. A key_valid pulse while key_ready is low is dropped, with no queuing.
- key_ready is 0 in S_EXEC and S_CAP and 1 in every other state.
- Digit entry: operand = {operand[11:0], digit}. The operand's counter increments. Once the counter reaches MAX_DIGITS, further digits are ignored and the value is unchanged.
- S_A:
  - Digit: appends to A.
  - Add/subtract: latches the pending op and goes to S_B with B = 0 and the B count = 0.
  - Equals: ignored.
- S_B:
  - Digit: appends to B.
  - Add/subtract: replaces the pending op.
  - Equals: goes to S_EXEC.
- S_EXEC: op_selected = pending op for SETTLE_CYCLES clocks (internal counter), then S_CAP.
- S_CAP (1 cycle):
  - op_selected is still driven.
  - Captures alu_bcd_out into display_bcd and alu_special into display_neg.
  - Sets overflow when op = add and alu_bcd_out < bcd1 (16-bit unsigned compare; valid for sums of 10000-19998, including 14-bit wrap). When overflow is set, display_bcd is forced to 0.
  - Next state S_SHOW.
- Latency: equals accepted at edge N; S_EXEC from N+1; result_valid = 1 from edge N+1+SETTLE_CYCLES+1 (N+3 at default).
- S_SHOW: op_selected = 00; result_valid = 1.
  - Add/subtract with no overflow and no negative result: A = result, A count = MAX_DIGITS (chaining), latch the op, go to S_B.
  - Add/subtract with overflow or a negative result: the key is ignored.
  - Digit: clears A, B and the flags, A = that digit, A count = 1, go to S_A.
  - Equals: ignored.
- Clear-all (4'hC) in any accepting state: same values as reset, except that clear_n is not involved.
- display_bcd:
  - S_A: A.
  - S_B: B when the B count > 0, else A.
  - S_SHOW: the captured result.
  - Registered; updates on the edge after the key.
- bcd1 and bcd2 are registered and stable from S_B through S_SHOW.
- Reset asserted mid-S_EXEC or mid-S_CAP: returns to S_A immediately; no capture occurs.

Decomposition:
- Shared package calc_pkg:
  - key-code constants KEY_ADD = 4'hA, KEY_SUB = 4'hB, KEY_EQ = 4'hE, KEY_CLR = 4'hC;
  - op constants OP_IDLE = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10;
  - state enum S_A, S_B, S_EXEC, S_CAP, S_SHOW.
- One natural sub-module: bcd_entry_reg, the 4-digit shift-in register with counter, saturation, load and clear. It is instantiated twice, for A and B.

Test Plan:
- Keys 1,2,3,A,4,5,E -> bcd1 = 16'h0123, bcd2 = 16'h0045, op_selected = 01 for 2 cycles; result_valid at N+3; display_bcd = 16'h0168, display_neg = 0.
- Keys 2,0,B,5,0,E -> op_selected = 10; display_bcd = 16'h0030, display_neg = 1, overflow = 0.
- Keys 9,9,9,9,A,9,9,9,9,E -> overflow = 1, display_bcd = 0. A following A key is ignored; digit 7 -> S_A, display_bcd = 16'h0007, overflow = 0.
- Keys 1,2,3,4,5 -> display_bcd = 16'h1234 (fifth digit ignored). Then A,1,E -> 16'h1235. Then B,5,E (chain) -> 16'h1230.
- Key pulses issued during S_EXEC/S_CAP (key_ready = 0) -> dropped, with the result unchanged. 4'hC in S_B -> all outputs return to their reset values.
- clear_n driven low mid-S_EXEC, asynchronously between edges -> outputs reach reset values immediately; result_valid never rises.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared key codes, ALU op encodings and sequencer states for the calculator controller.
package calc_pkg;

    localparam int         MAX_DIGITS = 4;
    localparam logic [2:0] MAX_CNT    = 3'(MAX_DIGITS);

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hC;

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_EXEC = 3'd2,
        S_CAP  = 3'd3,
        S_SHOW = 3'd4
    } state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

    function automatic logic [1:0] key_to_op(input logic [3:0] k);
        return (k == KEY_SUB) ? OP_SUB : OP_ADD;
    endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// Four-digit BCD shift-in register with saturating digit count, parallel load and clear.
module bcd_entry_reg
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        clear_n,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic [2:0]  load_cnt,
    input  logic        shift,
    input  logic [3:0]  digit,
    input  logic [15:0] alt_val,
    output logic [15:0] value,
    output logic [15:0] disp_nxt
);

    logic [15:0] value_q, value_d;
    logic [2:0]  count_q, count_d;

    // Next value: clear beats load beats digit shift; full register ignores digits.
    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (clr) begin
            value_d = 16'h0000;
            count_d = 3'd0;
        end else if (load) begin
            value_d = load_val;
            count_d = load_cnt;
        end else if (shift) begin
            if (count_q < MAX_CNT) begin
                value_d = {value_q[11:0], digit};
                count_d = count_q + 3'd1;
            end else begin
                value_d = value_q;
            end
        end else begin
            value_d = value_q;
        end
    end

    // Operand storage.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            value_q <= 16'h0000;
            count_q <= 3'd0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign value    = value_q;
    // An empty operand shows the caller's fallback value instead of zero.
    assign disp_nxt = (count_d != 3'd0) ? value_d : alt_val;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad sequencer for the two-operand BCD add/subtract ALU: entry, execute, capture, show, chain.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        key_ready,
    output logic [15:0] bcd1,
    output logic [15:0] bcd2,
    output logic [1:0]  op_selected,
    input  logic [15:0] alu_bcd_out,
    input  logic        alu_special,
    output logic [15:0] display_bcd,
    output logic        display_neg,
    output logic        result_valid,
    output logic        overflow
);

    state_e      state_q, state_d;
    logic [1:0]  pend_op_q, pend_op_d, op_sel_q, op_sel_d;
    logic [3:0]  settle_q, settle_d;
    logic        key_ready_q, key_ready_d;
    logic        disp_neg_q, disp_neg_d, valid_q, valid_d, ovf_q, ovf_d;
    logic [15:0] disp_q, disp_d;

    logic        key_acc_s, is_op_s, ovf_s;
    logic        a_clr_s, a_load_s, a_shift_s, b_clr_s, b_shift_s;
    logic [15:0] a_load_val_s, a_val_s, b_val_s, a_disp_s, b_disp_s;
    logic [2:0]  a_load_cnt_s;

    assign key_acc_s = key_valid & key_ready_q;
    assign is_op_s   = (key_code == KEY_ADD) || (key_code == KEY_SUB);
    // A carry out of the fourth digit leaves the wrapped sum smaller than operand A.
    assign ovf_s     = (pend_op_q == OP_ADD) && (alu_bcd_out < a_val_s);

    bcd_entry_reg u_opa (
        .clk      (clk),
        .clear_n  (clear_n),
        .clr      (a_clr_s),
        .load     (a_load_s),
        .load_val (a_load_val_s),
        .load_cnt (a_load_cnt_s),
        .shift    (a_shift_s),
        .digit    (key_code),
        .alt_val  (16'h0000),
        .value    (a_val_s),
        .disp_nxt (a_disp_s)
    );

    bcd_entry_reg u_opb (
        .clk      (clk),
        .clear_n  (clear_n),
        .clr      (b_clr_s),
        .load     (1'b0),
        .load_val (16'h0000),
        .load_cnt (3'd0),
        .shift    (b_shift_s),
        .digit    (key_code),
        .alt_val  (a_disp_s),
        .value    (b_val_s),
        .disp_nxt (b_disp_s)
    );

    // Next-state and operand-control decode; clear-all overrides whatever the state chose.
    always_comb begin
        state_d      = state_q;
        pend_op_d    = pend_op_q;
        settle_d     = settle_q;
        disp_neg_d   = disp_neg_q;
        valid_d      = valid_q;
        ovf_d        = ovf_q;
        a_clr_s      = 1'b0;
        a_load_s     = 1'b0;
        a_shift_s    = 1'b0;
        a_load_val_s = 16'h0000;
        a_load_cnt_s = 3'd0;
        b_clr_s      = 1'b0;
        b_shift_s    = 1'b0;
        case (state_q)
            S_A: begin
                if (key_acc_s && is_digit(key_code)) begin
                    a_shift_s = 1'b1;
                end else if (key_acc_s && is_op_s) begin
                    pend_op_d = key_to_op(key_code);
                    b_clr_s   = 1'b1;
                    state_d   = S_B;
                end else begin
                    state_d = S_A;
                end
            end
            S_B: begin
                if (key_acc_s && is_digit(key_code)) begin
                    b_shift_s = 1'b1;
                end else if (key_acc_s && is_op_s) begin
                    pend_op_d = key_to_op(key_code);
                end else if (key_acc_s && (key_code == KEY_EQ)) begin
                    settle_d = 4'd0;
                    state_d  = S_EXEC;
                end else begin
                    state_d = S_B;
                end
            end
            S_EXEC: begin
                if (settle_q == 4'(SETTLE_CYCLES - 1)) begin
                    state_d = S_CAP;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            S_CAP: begin
                valid_d    = 1'b1;
                disp_neg_d = alu_special;
                ovf_d      = ovf_s;
                state_d    = S_SHOW;
            end
            S_SHOW: begin
                if (key_acc_s && is_op_s && !ovf_q && !disp_neg_q) begin
                    a_load_s     = 1'b1;
                    a_load_val_s = disp_q;
                    a_load_cnt_s = MAX_CNT;
                    b_clr_s      = 1'b1;
                    pend_op_d    = key_to_op(key_code);
                    valid_d      = 1'b0;
                    state_d      = S_B;
                end else if (key_acc_s && is_digit(key_code)) begin
                    a_load_s     = 1'b1;
                    a_load_val_s = {12'h000, key_code};
                    a_load_cnt_s = 3'd1;
                    b_clr_s      = 1'b1;
                    valid_d      = 1'b0;
                    disp_neg_d   = 1'b0;
                    ovf_d        = 1'b0;
                    state_d      = S_A;
                end else begin
                    state_d = S_SHOW;
                end
            end
            default: begin
                state_d = S_A;
            end
        endcase
        if (key_acc_s && (key_code == KEY_CLR)) begin
            state_d    = S_A;
            pend_op_d  = OP_IDLE;
            settle_d   = 4'd0;
            disp_neg_d = 1'b0;
            valid_d    = 1'b0;
            ovf_d      = 1'b0;
            a_clr_s    = 1'b1;
            b_clr_s    = 1'b1;
        end else begin
            a_clr_s = a_clr_s;
        end
    end

    // Registered outputs are decoded from the state being entered.
    always_comb begin
        key_ready_d = !((state_d == S_EXEC) || (state_d == S_CAP));
        op_sel_d    = ((state_d == S_EXEC) || (state_d == S_CAP)) ? pend_op_d : OP_IDLE;
        case (state_d)
            S_A:     disp_d = a_disp_s;
            S_B:     disp_d = b_disp_s;
            S_SHOW: begin
                if (state_q == S_CAP) begin
                    disp_d = ovf_s ? 16'h0000 : alu_bcd_out;
                end else begin
                    disp_d = disp_q;
                end
            end
            default: disp_d = disp_q;
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= S_A;
            pend_op_q   <= OP_IDLE;
            op_sel_q    <= OP_IDLE;
            settle_q    <= 4'd0;
            key_ready_q <= 1'b1;
            disp_neg_q  <= 1'b0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            disp_q      <= 16'h0000;
        end else begin
            state_q     <= state_d;
            pend_op_q   <= pend_op_d;
            op_sel_q    <= op_sel_d;
            settle_q    <= settle_d;
            key_ready_q <= key_ready_d;
            disp_neg_q  <= disp_neg_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
            disp_q      <= disp_d;
        end
    end

    assign key_ready    = key_ready_q;
    assign bcd1         = a_val_s;
    assign bcd2         = b_val_s;
    assign op_selected  = op_sel_q;
    assign display_bcd  = disp_q;
    assign display_neg  = disp_neg_q;
    assign result_valid = valid_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a decimal-arithmetic reference model and a BCD ALU stand-in.
module tb_calc_sequencer;

    localparam int SETTLE = 1;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        key_ready, alu_special, display_neg, result_valid, overflow;
    logic [15:0] bcd1, bcd2, alu_bcd_out, display_bcd;
    logic [1:0]  op_selected;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    calc_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk          (clk),
        .clear_n      (clear_n),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ready    (key_ready),
        .bcd1         (bcd1),
        .bcd2         (bcd2),
        .op_selected  (op_selected),
        .alu_bcd_out  (alu_bcd_out),
        .alu_special  (alu_special),
        .display_bcd  (display_bcd),
        .display_neg  (display_neg),
        .result_valid (result_valid),
        .overflow     (overflow)
    );

    function automatic int from_bcd(input logic [15:0] v);
        return 1000 * int'(v[15:12]) + 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [15:0] alu_fn(input logic [15:0] x, input logic [15:0] y, input logic [1:0] op);
        int a, b;
        a = from_bcd(x);
        b = from_bcd(y);
        if (op == 2'b01) return to_bcd((a + b) % 10000);
        else if (op == 2'b10) return (a >= b) ? to_bcd(a - b) : to_bcd(b - a);
        else return 16'h0000;
    endfunction

    assign alu_bcd_out = alu_fn(bcd1, bcd2, op_selected);
    assign alu_special = (op_selected == 2'b10) && (from_bcd(bcd1) < from_bcd(bcd2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: modes 0 entering A, 1 entering B, 2 busy computing, 3 showing result.
    int m_mode, m_a, m_b, m_acnt, m_bcnt, m_op, m_busy, m_disp, m_opsel;
    bit m_neg, m_valid, m_ovf;

    task automatic model_reset();
        m_mode = 0; m_a = 0; m_b = 0; m_acnt = 0; m_bcnt = 0; m_op = 0;
        m_busy = 0; m_disp = 0; m_opsel = 0; m_neg = 0; m_valid = 0; m_ovf = 0;
    endtask

    task automatic finish_calc();
        m_mode = 3; m_opsel = 0; m_valid = 1; m_neg = 0; m_ovf = 0;
        if (m_op == 1) begin
            if (m_a + m_b > 9999) begin m_ovf = 1; m_disp = 0; end
            else m_disp = m_a + m_b;
        end else if (m_a >= m_b) m_disp = m_a - m_b;
        else begin m_disp = m_b - m_a; m_neg = 1; end
    endtask

    task automatic model_step();
        int k;
        k = int'(key_code);
        if (!clear_n) model_reset();
        else if (m_mode == 2) begin
            m_busy--;
            if (m_busy == 0) finish_calc();
        end else if (key_valid) begin
            if (k == 12) model_reset();
            else if (k <= 9) begin
                if (m_mode == 0) begin
                    if (m_acnt < 4) begin m_a = m_a * 10 + k; m_acnt++; end
                    m_disp = m_a;
                end else if (m_mode == 1) begin
                    if (m_bcnt < 4) begin m_b = m_b * 10 + k; m_bcnt++; end
                    m_disp = m_b;
                end else begin
                    m_mode = 0; m_a = k; m_acnt = 1; m_b = 0; m_bcnt = 0;
                    m_ovf = 0; m_neg = 0; m_valid = 0; m_disp = k;
                end
            end else if (k == 10 || k == 11) begin
                if (m_mode == 0) begin
                    m_op = k - 9; m_b = 0; m_bcnt = 0; m_mode = 1;
                end else if (m_mode == 1) m_op = k - 9;
                else if (!m_ovf && !m_neg) begin
                    m_a = m_disp; m_acnt = 4; m_b = 0; m_bcnt = 0;
                    m_op = k - 9; m_mode = 1; m_valid = 0;
                end
            end else if (k == 14 && m_mode == 1) begin
                m_mode = 2; m_busy = SETTLE + 1; m_opsel = m_op;
            end
        end
    endtask

    // Single compare process: step the model on each rising edge, compare shortly after it.
    always begin
        @(posedge clk);
        model_step();
        #1;
        check("key_ready", 32'(key_ready), 32'(m_mode != 2));
        check("bcd1", 32'(bcd1), 32'(to_bcd(m_a)));
        check("bcd2", 32'(bcd2), 32'(to_bcd(m_b)));
        check("op_selected", 32'(op_selected), 32'(m_opsel));
        check("display_bcd", 32'(display_bcd), 32'(to_bcd(m_disp)));
        check("display_neg", 32'(display_neg), 32'(m_neg));
        check("result_valid", 32'(result_valid), 32'(m_valid));
        check("overflow", 32'(overflow), 32'(m_ovf));
    end

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int n;
        n = 0;
        while (!result_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!result_valid) check({name, "_timeout"}, 32'(result_valid), 32'd1);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_ready"}, 32'(key_ready), 32'd1);
        check({name, "_bcd1"}, 32'(bcd1), 32'h0);
        check({name, "_bcd2"}, 32'(bcd2), 32'h0);
        check({name, "_op"}, 32'(op_selected), 32'h0);
        check({name, "_disp"}, 32'(display_bcd), 32'h0);
        check({name, "_flags"}, 32'({display_neg, result_valid, overflow}), 32'h0);
    endtask

    initial begin
        model_reset();
        #12;
        check_reset_vals("por");
        @(negedge clk);
        clear_n = 1'b1;

        press(4'h1); press(4'h2); press(4'h3); press(4'hA); press(4'h4); press(4'h5);
        check("s1_bcd1", 32'(bcd1), 32'h0123);
        check("s1_bcd2", 32'(bcd2), 32'h0045);
        press(4'hE);
        check("s1_exec_op", 32'(op_selected), 32'h1);
        check("s1_exec_ready", 32'(key_ready), 32'h0);
        @(negedge clk);
        check("s1_cap_op", 32'(op_selected), 32'h1);
        check("s1_cap_valid", 32'(result_valid), 32'h0);
        @(negedge clk);
        check("s1_show_valid", 32'(result_valid), 32'h1);
        check("s1_show_op", 32'(op_selected), 32'h0);
        check("s1_disp", 32'(display_bcd), 32'h0168);
        check("s1_neg", 32'(display_neg), 32'h0);

        press(4'h2); press(4'h0); press(4'hB); press(4'h5); press(4'h0); press(4'hE);
        check("s2_op", 32'(op_selected), 32'h2);
        wait_result("s2");
        check("s2_disp", 32'(display_bcd), 32'h0030);
        check("s2_neg", 32'(display_neg), 32'h1);
        check("s2_ovf", 32'(overflow), 32'h0);

        press(4'h9); press(4'h9); press(4'h9); press(4'h9); press(4'hA);
        press(4'h9); press(4'h9); press(4'h9); press(4'h9); press(4'hE);
        wait_result("s3");
        check("s3_ovf", 32'(overflow), 32'h1);
        check("s3_disp", 32'(display_bcd), 32'h0000);
        press(4'hA);
        check("s3_ign_valid", 32'(result_valid), 32'h1);
        check("s3_ign_ovf", 32'(overflow), 32'h1);
        press(4'h7);
        check("s3_new_disp", 32'(display_bcd), 32'h0007);
        check("s3_new_ovf", 32'(overflow), 32'h0);

        press(4'hC);
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        check("s4_sat", 32'(display_bcd), 32'h1234);
        press(4'hA); press(4'h1); press(4'hE);
        wait_result("s4a");
        check("s4_sum", 32'(display_bcd), 32'h1235);
        press(4'hB);
        check("s4_chain_a", 32'(bcd1), 32'h1235);
        press(4'h5); press(4'hE);
        wait_result("s4b");
        check("s4_chain", 32'(display_bcd), 32'h1230);

        press(4'hC); press(4'h6); press(4'hA); press(4'h2); press(4'hE);
        press(4'h9); press(4'h1);
        wait_result("s5");
        check("s5_drop", 32'(display_bcd), 32'h0008);
        check("s5_bcd2", 32'(bcd2), 32'h0002);

        press(4'h3); press(4'hA); press(4'h4);
        check("s6_b_disp", 32'(display_bcd), 32'h0004);
        press(4'hC);
        check_reset_vals("clr");

        press(4'h1); press(4'hA); press(4'h1); press(4'hE);
        #2;
        clear_n = 1'b0;
        #1;
        check_reset_vals("async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("async_hold_valid", 32'(result_valid), 32'h0);
        end
        clear_n = 1'b1;

        press(4'h5); press(4'hA); press(4'h5); press(4'hE);
        wait_result("s7");
        check("s7_disp", 32'(display_bcd), 32'h0010);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
